// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin grant controller for the shared 8:1 single-bit mux
//
// Purpose: grants one of eight requesters at a time, drives the registered
// 3-bit mux select, and registers the selected data bit with a valid flag.
// Optional feature macro: ARB_BURST_LIMIT_EN (forces a grant hand-over after
// MAX_HOLD consecutive granted cycles when another requester is pending).
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   req       in   N_REQ  per-requester level request
//   in        in   N_REQ  per-requester data bit
//   gnt       out  N_REQ  one-hot registered grant, zero when idle
//   sel       out  3      registered index of the granted requester
//   busy      out  1      high while a grant is active
//   out       out  1      registered copy of in[sel]
//   out_valid out  1      out carries data from a granted requester
module mux_rr_arbiter #(
   parameter int N_REQ    = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] in,
   output logic [N_REQ-1:0] gnt,
   output logic [2:0]       sel,
   output logic             busy,
   output logic             out,
   output logic             out_valid
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   logic       state;
   logic [2:0] last;
   logic [N_REQ-1:0] cand;
   logic       win_found;
   logic [2:0] win_idx;
   logic [2:0] idx;
   logic       hold_expire;
   logic       data_ok;

   // While granted, the current owner is masked out so the scan only finds
   // other pending requesters; on release its req is low anyway.
   always_comb begin
      cand = (state == ST_GRANT) ? (req & ~gnt) : req;
   end

   // Rotating scan starting just after the last winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      idx       = 3'd0;
      for (int i = 1; i <= 8; i++) begin
         idx = last + i[2:0];
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

`ifdef ARB_BURST_LIMIT_EN
   logic [7:0] hold_cnt;

   always_comb begin
      hold_expire = (hold_cnt == 8'(MAX_HOLD - 1));
   end

   // Counts granted cycles; restarts on every new grant and saturates at the
   // limit when nobody else is waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= 8'd0;
      end else if ((state == ST_IDLE) ||
                   (!req[sel] || (hold_expire && win_found))) begin
         hold_cnt <= 8'd0;
      end else if (!hold_expire) begin
         hold_cnt <= hold_cnt + 8'd1;
      end
   end
`else
   always_comb begin
      hold_expire = 1'b0;
   end
`endif

   always_comb begin
      data_ok = (state == ST_GRANT) && req[sel];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         gnt   <= '0;
         sel   <= 3'd0;
         last  <= 3'd7;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  state <= ST_GRANT;
                  gnt   <= N_REQ'(1) << win_idx;
                  sel   <= win_idx;
                  last  <= win_idx;
               end
            end
            default: begin
               // Hand over on release, or on burst expiry with a waiter.
               if (!req[sel] || (hold_expire && win_found)) begin
                  if (win_found) begin
                     gnt  <= N_REQ'(1) << win_idx;
                     sel  <= win_idx;
                     last <= win_idx;
                  end else begin
                     state <= ST_IDLE;
                     gnt   <= '0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out       <= data_ok ? in[sel] : 1'b0;
         out_valid <= data_ok;
      end
   end

   assign busy = (state == ST_GRANT);

endmodule
